// File: rtl/gear_shifter.sv
// Gear selector: validates up/down/reverse requests against speed and inserts a clutch interval.
// Optional automatic shifting is enabled by defining GEAR_AUTO_SHIFT_EN (adds the auto_mode input).
module gear_shifter #(
    parameter int SPEED_BITS  = 7,
    parameter int SHIFT_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key2,
    input  logic                  shift_up,
    input  logic                  shift_down,
    input  logic                  rev_req,
`ifdef GEAR_AUTO_SHIFT_EN
    input  logic                  auto_mode,
`endif
    input  logic [SPEED_BITS-1:0] speed,
    output logic [2:0]            gear,
    output logic                  shift_busy,
    output logic                  shift_reject
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef logic [SPEED_BITS-1:0] spd_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] target;
    logic       up_hist, dn_hist, rv_hist;

    logic       up_edge, dn_edge, rv_edge;
    logic       man_en;
    logic       req_valid, req_legal, req_silent;
    logic [2:0] req_target;

    function automatic spd_t win_lo(input logic [2:0] g);
        case (g)
            3'd2:    return spd_t'(15);
            3'd3:    return spd_t'(35);
            3'd4:    return spd_t'(55);
            3'd5:    return spd_t'(75);
            default: return '0;
        endcase
    endfunction

    function automatic spd_t win_hi(input logic [2:0] g);
        case (g)
            3'd1:    return spd_t'(25);
            3'd2:    return spd_t'(45);
            3'd3:    return spd_t'(65);
            3'd4:    return spd_t'(85);
            3'd5:    return spd_t'(99);
            default: return '0;
        endcase
    endfunction

    function automatic logic in_win(input logic [2:0] g, input spd_t s);
        return (s >= win_lo(g)) && (s <= win_hi(g));
    endfunction

    assign up_edge = shift_up   & ~up_hist;
    assign dn_edge = shift_down & ~dn_hist;
    assign rv_edge = rev_req    & ~rv_hist;

`ifdef GEAR_AUTO_SHIFT_EN
    assign man_en = ~auto_mode;
`else
    assign man_en = 1'b1;
`endif

    // Request arbitration: reverse first, then manual up/down, then automatic requests.
    always_comb begin
        req_valid  = 1'b0;
        req_legal  = 1'b0;
        req_silent = 1'b0;
        req_target = gear;
        if (rv_edge) begin
            req_valid = 1'b1;
            if (gear == 3'd0) begin
                req_target = 3'd6;
                req_legal  = (speed == '0);
            end else if (gear == 3'd6) begin
                req_target = 3'd0;
                req_legal  = (speed == '0);
            end
        end else if (man_en && up_edge && dn_edge) begin
            req_valid = 1'b1;
        end else if (man_en && up_edge) begin
            req_valid = 1'b1;
            if (gear <= 3'd4) begin
                req_target = gear + 3'd1;
                req_legal  = in_win(gear + 3'd1, speed);
            end
        end else if (man_en && dn_edge) begin
            req_valid = 1'b1;
            if (gear == 3'd1) begin
                req_target = 3'd0;
                req_legal  = 1'b1;
            end else if (gear >= 3'd2 && gear <= 3'd5) begin
                req_target = gear - 3'd1;
                req_legal  = in_win(gear - 3'd1, speed);
            end
        end
`ifdef GEAR_AUTO_SHIFT_EN
        else if (auto_mode && gear >= 3'd1 && gear <= 3'd5) begin
            if (gear < 3'd5 && speed >= win_hi(gear)) begin
                req_valid  = 1'b1;
                req_silent = 1'b1;
                req_target = gear + 3'd1;
                req_legal  = in_win(gear + 3'd1, speed);
            end else if (gear > 3'd1 && speed <= win_lo(gear)) begin
                req_valid  = 1'b1;
                req_silent = 1'b1;
                req_target = gear - 3'd1;
                req_legal  = in_win(gear - 3'd1, speed);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            gear         <= '0;
            shift_busy   <= 1'b0;
            shift_reject <= 1'b0;
            cnt          <= '0;
            target       <= '0;
            up_hist      <= 1'b1;
            dn_hist      <= 1'b1;
            rv_hist      <= 1'b1;
        end else begin
            up_hist      <= shift_up;
            dn_hist      <= shift_down;
            rv_hist      <= rev_req;
            shift_reject <= 1'b0;
            if (!key2) begin
                state      <= IDLE;
                gear       <= '0;
                shift_busy <= 1'b0;
                cnt        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_legal) begin
                            state      <= SHIFT;
                            gear       <= '0;
                            shift_busy <= 1'b1;
                            target     <= req_target;
                            cnt        <= 4'(SHIFT_DELAY - 1);
                        end else if (req_valid && !req_silent) begin
                            shift_reject <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (cnt == '0) begin
                            state      <= IDLE;
                            gear       <= target;
                            shift_busy <= 1'b0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gear_shifter.sv
// Self-checking bench for gear_shifter: directed test-plan steps followed by random stimulus vs a reference model.
module tb_gear_shifter;
    localparam int SB = 7;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst, key2, shift_up, shift_down, rev_req;
    logic [SB-1:0] speed;
    logic [2:0]    gear;
    logic          shift_busy, shift_reject;
`ifdef GEAR_AUTO_SHIFT_EN
    logic          auto_mode;
`endif

    always #5 clk = ~clk;

    gear_shifter #(.SPEED_BITS(SB), .SHIFT_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .key2(key2),
        .shift_up(shift_up), .shift_down(shift_down), .rev_req(rev_req),
`ifdef GEAR_AUTO_SHIFT_EN
        .auto_mode(auto_mode),
`endif
        .speed(speed), .gear(gear), .shift_busy(shift_busy), .shift_reject(shift_reject)
    );

    int vectors = 0;
    int miscompares = 0;

    // Speed window table indexed by gear number.
    int lo_w [7] = '{0, 0, 15, 35, 55, 75, 0};
    int hi_w [7] = '{0, 25, 45, 65, 85, 99, 99};

    // Model: m_n counts neutral cycles shown so far during a shift (0 = no shift pending).
    int m_gear, m_n, m_tgt;
    bit m_rej, h_up, h_dn, h_rv;

    function automatic bit in_win(int g, int s);
        return (s >= lo_w[g]) && (s <= hi_w[g]);
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit eu, ed, er, want, legal, silent, manual;
        int tgt, s;
        if (!rst) begin
            m_gear = 0; m_n = 0; m_rej = 0; m_tgt = 0;
            h_up = 1; h_dn = 1; h_rv = 1;
            return;
        end
        eu = shift_up && !h_up;
        ed = shift_down && !h_dn;
        er = rev_req && !h_rv;
        h_up = shift_up; h_dn = shift_down; h_rv = rev_req;
        m_rej = 0;
        if (!key2) begin
            m_gear = 0; m_n = 0;
            return;
        end
        if (m_n != 0) begin
            if (m_n == SD) begin m_gear = m_tgt; m_n = 0; end
            else m_n++;
            return;
        end
        s = int'(speed);
        want = 0; legal = 0; silent = 0; tgt = m_gear; manual = 1;
`ifdef GEAR_AUTO_SHIFT_EN
        if (auto_mode) manual = 0;
`endif
        if (er) begin
            want = 1;
            if (m_gear == 0) tgt = 6;
            else if (m_gear == 6) tgt = 0;
            legal = (m_gear == 0 || m_gear == 6) && s == 0;
        end else if (manual && eu && ed) begin
            want = 1;
        end else if (manual && eu) begin
            want = 1;
            if (m_gear <= 4) begin tgt = m_gear + 1; legal = in_win(tgt, s); end
        end else if (manual && ed) begin
            want = 1;
            if (m_gear == 1) begin tgt = 0; legal = 1; end
            else if (m_gear >= 2 && m_gear <= 5) begin tgt = m_gear - 1; legal = in_win(tgt, s); end
        end
`ifdef GEAR_AUTO_SHIFT_EN
        else if (auto_mode && m_gear >= 1 && m_gear <= 5) begin
            if (m_gear < 5 && s >= hi_w[m_gear]) begin
                want = 1; silent = 1; tgt = m_gear + 1; legal = in_win(tgt, s);
            end else if (m_gear > 1 && s <= lo_w[m_gear]) begin
                want = 1; silent = 1; tgt = m_gear - 1; legal = in_win(tgt, s);
            end
        end
`endif
        if (want && legal) begin
            m_tgt = tgt; m_gear = 0; m_n = 1;
        end else if (want && !silent) begin
            m_rej = 1;
        end
    endtask

    task automatic cyc(input bit u, input bit d, input bit r, input int spd);
        @(negedge clk);
        shift_up = u; shift_down = d; rev_req = r; speed = SB'(spd);
        @(posedge clk);
        model_edge();
        #1;
        check("gear", 8'(gear), 8'(m_gear));
        check("busy", 8'(shift_busy), 8'(m_n != 0));
        check("reject", 8'(shift_reject), 8'(m_rej));
    endtask

    task automatic press(input bit u, input bit d, input bit r, input int spd, input int n);
        cyc(u, d, r, spd);
        repeat (n) cyc(0, 0, 0, spd);
    endtask

    bit ru, rd, rr;
    int rs;

    initial begin
        rst = 0; key2 = 0; shift_up = 0; shift_down = 0; rev_req = 0; speed = '0;
`ifdef GEAR_AUTO_SHIFT_EN
        auto_mode = 0;
`endif
        repeat (2) cyc(0, 0, 0, 0);
        check("rst_gear", 8'(gear), 8'd0);
        rst = 1; key2 = 1;
        cyc(0, 0, 0, 0);

        // Up from neutral: four neutral cycles, then gear 1
        cyc(1, 0, 0, 0);
        check("tp1_busy", 8'(shift_busy), 8'd1);
        repeat (3) cyc(0, 0, 0, 0);
        check("tp1_neutral", 8'(gear), 8'd0);
        cyc(0, 0, 0, 0);
        check("tp1_gear1", 8'(gear), 8'd1);
        cyc(0, 0, 0, 0);

        cyc(1, 0, 0, 10);
        check("tp2_reject", 8'(shift_reject), 8'd1);
        press(0, 0, 0, 10, 2);
        check("tp2_keep1", 8'(gear), 8'd1);
        press(1, 0, 0, 20, 6);
        check("tp2_gear2", 8'(gear), 8'd2);
        press(1, 0, 0, 40, 6);
        check("tp3_gear3", 8'(gear), 8'd3);
        press(0, 1, 0, 40, 6);
        check("tp3_down2", 8'(gear), 8'd2);
        press(1, 0, 0, 40, 6);
        cyc(0, 1, 0, 50);
        check("tp3_reject", 8'(shift_reject), 8'd1);
        press(0, 0, 0, 50, 2);
        check("tp3_keep3", 8'(gear), 8'd3);
        press(0, 1, 0, 20, 6);
        press(0, 1, 0, 10, 6);
        press(0, 1, 0, 10, 6);
        check("to_neutral", 8'(gear), 8'd0);

        press(0, 0, 1, 0, 6);
        check("tp4_rev", 8'(gear), 8'd6);
        cyc(0, 0, 1, 5);
        check("tp4_reject", 8'(shift_reject), 8'd1);
        press(0, 0, 0, 5, 2);
        press(0, 0, 1, 0, 6);
        check("tp4_back0", 8'(gear), 8'd0);

        // Ignition drop mid-shift aborts to neutral
        press(1, 0, 0, 0, 1);
        key2 = 0;
        cyc(0, 0, 0, 0);
        check("tp5_abort_gear", 8'(gear), 8'd0);
        check("tp5_abort_busy", 8'(shift_busy), 8'd0);
        key2 = 1;
        press(0, 0, 0, 0, 6);
        check("tp5_no_resume", 8'(gear), 8'd0);
        cyc(1, 1, 0, 0);
        check("tp5_both_rej", 8'(shift_reject), 8'd1);
        press(0, 0, 0, 0, 3);
        check("tp5_both_keep", 8'(gear), 8'd0);

`ifdef GEAR_AUTO_SHIFT_EN
        press(1, 0, 0, 20, 6);
        press(1, 0, 0, 30, 6);
        auto_mode = 1;
        for (int s = 30; s <= 45; s++) cyc(0, 0, 0, s);
        repeat (6) cyc(0, 0, 0, 45);
        check("auto_up3", 8'(gear), 8'd3);
        press(0, 0, 0, 35, 7);
        check("auto_down2", 8'(gear), 8'd2);
        press(1, 0, 0, 40, 6);
        check("auto_manual_ign", 8'(gear), 8'd2);
        auto_mode = 0;
`endif

        // Random phase
        ru = 0; rd = 0; rr = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) ru = ~ru;
            if ($urandom_range(3) == 0) rd = ~rd;
            if ($urandom_range(7) == 0) rr = ~rr;
            if ($urandom_range(5) == 0) rs = $urandom_range(110);
            else if ($urandom_range(3) == 0) rs = 0;
            key2 = ($urandom_range(80) != 0);
            rst  = ($urandom_range(400) != 0);
`ifdef GEAR_AUTO_SHIFT_EN
            if ($urandom_range(50) == 0) auto_mode = ~auto_mode;
`endif
            cyc(ru, rd, rr, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gear_shifter.md
Name: gear_shifter

Overview:
- Upstream stage of the speed model (accel/brake speed counter); generates the 3-bit gear code that the speed counter consumes.
- Converts driver up/down/reverse button levels into validated gear changes.
- Checks each request against the current speed fed back from the speed counter.
- Inserts a clutch interval (gear forced to neutral) while each shift completes.

Parameters:
SPEED_BITS, 7, width of speed feedback input (covers 0..99)
SHIFT_DELAY, 4, clutch interval in clock cycles with gear held at 0 during a shift (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset)
key2  input  1  ignition; 1 = engine on
shift_up  input  1  up-shift button level, synchronous to clk
shift_down  input  1  down-shift button level
rev_req  input  1  reverse toggle button level
speed  input  SPEED_BITS  current speed from the speed counter
gear  output  3  0 = neutral, 1..5 = forward, 6 = reverse; 7 never driven
shift_busy  output  1  high while in SHIFT state
shift_reject  output  1  one-cycle pulse when a request is refused

Behaviour:
- Reset (rst==0 at clk edge):
  - gear=0, shift_busy=0, shift_reject=0, state=IDLE, delay counter=0.
  - Button history registers set to 1, so a button held through reset produces no edge.
- Edge detect: a request is the cycle where the button is 1 and its history register was 0. History registers update every cycle.
- Speed windows [lo,hi] per gear:
  - gear 1 = [0,25], 2 = [15,45], 3 = [35,65], 4 = [55,85], 5 = [75,99].
  - Reverse (6) window = [0,99].
- Target and legality, evaluated in IDLE on the request cycle:
  - up from 0: target 1, legal if speed<=25.
  - up from g in 1..4: target g+1, legal if lo(g+1)<=speed<=hi(g+1).
  - up from 5 or 6: reject.
  - down from g in 2..5: target g-1, legal if lo(g-1)<=speed<=hi(g-1).
  - down from 1: target 0, always legal.
  - down from 0 or 6: reject.
  - rev from 0: target 6, legal only if speed==0.
  - rev from 6: target 0, legal only if speed==0.
  - rev from any other gear: reject.
- Simultaneous request edges in the same cycle:
  - rev wins.
  - If up and down occur together without rev: reject, no shift.
- FSM states IDLE and SHIFT:
  - IDLE, legal request: next cycle gear=0, shift_busy=1, target latched, counter loaded SHIFT_DELAY-1, state=SHIFT.
  - SHIFT: counter decrements each cycle. At counter==0, on the next edge gear=target, shift_busy=0, state=IDLE.
  - Net effect: gear reads 0 for exactly SHIFT_DELAY cycles; the new gear appears SHIFT_DELAY+1 cycles after the request edge.
  - IDLE, illegal request: shift_reject=1 for exactly one cycle (next cycle); gear unchanged.
  - Requests arriving during SHIFT are ignored: no reject, no queuing.
  - Speed is not re-checked after a shift is committed.
- Ignition:
  - key2==0: gear forced to 0 next edge; any SHIFT is aborted to IDLE; shift_busy=0; all requests ignored, no reject pulses.
  - History registers still track while key2==0, so a button held across key-on does not fire.
- rst low during SHIFT behaves as a full reset; the latched target is discarded.
- Speed comparisons are unsigned at SPEED_BITS width.
- Speed values above 99 fail every window except reverse.

Optional Feature:
- Macro: GEAR_AUTO_SHIFT_EN.
- When defined:
  - Adds input auto_mode (1 bit).
  - With auto_mode==1, key2==1, state IDLE and gear in 1..5:
    - Internal up-request when speed>=hi(gear) and gear<5.
    - Internal down-request when speed<=lo(gear) and gear>1.
  - Internal requests follow the same legality check and SHIFT sequence as manual ones.
  - Manual shift_up/shift_down edges are ignored while auto_mode==1.
  - rev_req is unaffected by auto_mode.
  - An illegal auto request is dropped silently (no shift_reject).
- When not defined: the auto_mode port is absent; behaviour is manual only, exactly as above.

Test Plan:
- Reset, then key2=1, speed=0, shift_up pulse → gear 0 for 4 cycles (shift_busy=1), gear=1 on cycle 5; no reject.
- gear=1, speed=10, shift_up pulse → shift_reject one cycle, gear stays 1. Repeat with speed=20 → gear goes 0 then 2.
- gear=3, speed=40, shift_down pulse → gear 2 after the clutch interval. gear=3, speed=50, shift_down → reject.
- gear=0, speed=0, rev_req pulse → gear=6. Then speed=5, rev_req → reject. Then speed=0, rev_req → gear=0.
- SHIFT in progress, key2 dropped → gear=0, shift_busy=0 next cycle. Also shift_up and shift_down rising together in IDLE → reject, gear unchanged.
- GEAR_AUTO_SHIFT_EN build: auto_mode=1, gear=2, speed ramps to 45 → auto upshift to 3. Speed falls to 35 → auto downshift to 2. Manual shift_up is ignored while auto_mode=1.
